// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up at the end.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic               is_div;
  logic               zero_div;
  logic               neg_q;
  logic               neg_r;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    sign_a = ~op[0] & A[WIDTH-1];
    sign_b = ~op[0] & B[WIDTH-1];
    abs_a  = sign_a ? -A : A;
    abs_b  = sign_b ? -B : B;
  end

  // acc doubles as {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = div_sh >= {1'b0, opd};
    div_rem  = div_ge ? (div_sh[WIDTH-1:0] - opd) : div_sh[WIDTH-1:0];
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      count       <= '0;
      acc         <= '0;
      opd         <= '0;
      is_div      <= 1'b0;
      zero_div    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            is_div      <= op[1];
            neg_q       <= sign_a ^ sign_b;
            neg_r       <= sign_a;
            count       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (op[1] && (B == '0)) begin
              zero_div <= 1'b1;
              acc      <= {{WIDTH{1'b0}}, A};
              state    <= S_FIX;
            end else begin
              zero_div <= 1'b0;
              opd      <= op[1] ? abs_b : abs_a;
              acc      <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
              state    <= op[1] ? S_DIV : S_MUL;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_DIV: begin
          acc   <= {div_rem, acc[WIDTH-2:0], div_ge};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (zero_div) begin
            lo          <= '1;
            hi          <= acc[WIDTH-1:0];
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: cycle-level arithmetic model compared every cycle,
// directed cases with literal results, then randomized traffic.
module tb_mul_div_unit;
  logic        clk = 0, rst = 0, start = 0, mthi = 0, mtlo = 0;
  logic [1:0]  op = '0;
  logic [31:0] A = '0, B = '0, wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l,
                                 output logic z, output int lat);
    logic [63:0] p;
    longint q, r;
    z = 1'b0;
    lat = 33;
    case (o)
      2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); {h, l} = p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; {h, l} = p; end
      default: begin
        if (b == 0) begin
          l = 32'hFFFF_FFFF; h = a; z = 1'b1; lat = 1;
        end else if (o == 2'b10) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          l = q[31:0]; h = r[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Cycle-level model: pending result lands after the computed latency.
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        m_busy = 0, m_done = 0, m_dbz = 0, p_dbz = 0;
  int          m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_dbz = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1; m_busy = 0;
        end
      end else if (start) begin
        ref_op(op, A, B, p_hi, p_lo, p_dbz, m_cnt);
        m_busy = 1; m_dbz = 0;
      end else begin
        if (mthi) m_hi = wdata;
        if (mtlo) m_lo = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start = 1; op = o; A = a; B = b;
    @(negedge clk);
    start = 0; op = 2'($urandom); A = $urandom; B = $urandom;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  int lat;

  initial begin
    #1 rst = 1;
    #20;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk) rst = 0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk("t1_lat", lat, 33);
    chk("t1_hi", hi, 32'hFFFF_FFFE);
    chk("t1_lo", lo, 32'h0000_0001);

    run_op(2'b00, -32'sd3, 32'd7, lat);
    chk("t2_hi", hi, 32'hFFFF_FFFF);
    chk("t2_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b01, -32'sd3, 32'd7, lat);
    chk("t2u_hi", hi, 32'h0000_0006);
    chk("t2u_lo", lo, 32'hFFFF_FFEB);

    run_op(2'b10, -32'sd7, 32'd2, lat);
    chk("t3_lo", lo, 32'hFFFF_FFFD);
    chk("t3_hi", hi, 32'hFFFF_FFFF);

    run_op(2'b11, 32'd100, 32'd0, lat);
    chk("t4_lat", lat, 1);
    chk("t4_lo", lo, 32'hFFFF_FFFF);
    chk("t4_hi", hi, 32'h64);
    chk("t4_dbz", {31'd0, div_by_zero}, 32'd1);

    run_op(2'b11, 32'd100, 32'd7, lat);
    chk("t3u_lo", lo, 32'd14);
    chk("t3u_hi", hi, 32'd2);
    chk("t4_dbz_clr", {31'd0, div_by_zero}, 32'd0);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // Second start at E5 must be ignored.
    @(negedge clk); start = 1; op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    start = 1; op = 2'b00; A = 32'd3; B = 32'd7;
    @(negedge clk); start = 0;
    lat = 5;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t5_lat", lat, 33);
    chk("t5_hi", hi, 32'hFFFF_FFFE);
    chk("t5_lo", lo, 32'h0000_0001);

    // Reset in the middle of a divide.
    @(negedge clk); start = 1; op = 2'b10; A = 32'd1000; B = 32'd3;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd0);
    @(negedge clk) rst = 0;
    mtlo = 1; wdata = 32'h1234;
    @(negedge clk) mtlo = 0;
    chk("t6_mtlo", lo, 32'h1234);
    run_op(2'b01, 32'd3, 32'd5, lat);
    chk("t6_lat", lat, 33);
    chk("t6_lo2", lo, 32'd15);

    // Both move-to registers at once.
    @(negedge clk); mthi = 1; mtlo = 1; wdata = 32'hCAFE_F00D;
    @(negedge clk); mthi = 0; mtlo = 0;
    chk("mt_both_hi", hi, 32'hCAFE_F00D);
    chk("mt_both_lo", lo, 32'hCAFE_F00D);

    // Randomized traffic, including start/mthi/mtlo while busy and in the same cycle.
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 6) == 0;
      op    = 2'($urandom);
      A     = pick();
      B     = pick();
      mthi  = ($urandom % 5) == 0;
      mtlo  = ($urandom % 5) == 0;
      wdata = $urandom;
    end
    @(negedge clk);
    start = 0; mthi = 0; mtlo = 0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
